// File: rtl/buyruk_onbellek_pkg.sv
// Shared types and entry-format constants for the instruction-cache controller.
// An entry is {valid, tag[7:0], instruction[31:0]} = 41 bits.
package buyruk_onbellek_pkg;

    typedef enum logic [2:0] {
        TEMIZLE = 3'd0,
        BOSTA   = 3'd1,
        ARA     = 3'd2,
        ISTEK   = 3'd3,
        BEKLE   = 3'd4,
        YAZ     = 3'd5
    } durum_e;

    localparam int ENTRY_W   = 41;
    localparam int VALID_BIT = 40;
    localparam int TAG_MSB   = 39;
    localparam int TAG_LSB   = 32;
    localparam int DATA_MSB  = 31;

    localparam logic [4:0] WEN_ALL = 5'b11111;
    localparam logic [4:0] WEN_INV = 5'b10000;

    // True when the entry is valid and holds the requested tag.
    function automatic logic girdi_isabet(input logic [ENTRY_W-1:0] girdi,
                                          input logic [TAG_MSB-TAG_LSB:0] etiket);
        return girdi[VALID_BIT] & (girdi[TAG_MSB:TAG_LSB] == etiket);
    endfunction

    // Builds a valid entry from a tag and an instruction word.
    function automatic logic [ENTRY_W-1:0] girdi_olustur(input logic [TAG_MSB-TAG_LSB:0] etiket,
                                                        input logic [DATA_MSB:0]          buyruk);
        return {1'b1, etiket, buyruk};
    endfunction

endpackage

// File: rtl/buyruk_onbellek_denetleyici.sv
// Direct-mapped instruction-cache controller driving an external buyruk_ffram.
// One request in flight: lookup, refill from the memory bus on a miss, and a
// full invalidation sweep after reset or on a flush request.
module buyruk_onbellek_denetleyici
    import buyruk_onbellek_pkg::*;
#(
    parameter int IDX_W = 9,
    parameter int TAG_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ist_gecerli_i,
    input  logic [31:0]        ist_adres_i,
    output logic               ist_hazir_o,
    output logic               yanit_gecerli_o,
    output logic [31:0]        yanit_buyruk_o,
    input  logic               temizle_i,
    output logic               temizle_bitti_o,
    output logic               bel_istek_gecerli_o,
    output logic [31:0]        bel_adres_o,
    input  logic               bel_hazir_i,
    input  logic               bel_yanit_gecerli_i,
    input  logic [31:0]        bel_veri_i,
    output logic [4:0]         ram_wen_o,
    output logic [40:0]        ram_data_o,
    output logic [IDX_W-1:0]   ram_wadr_o,
    output logic [IDX_W-1:0]   ram_radr_o,
    input  logic [40:0]        ram_data_i
);

    localparam logic [IDX_W-1:0] SAYAC_SIFIR = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] SAYAC_SON   = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] SAYAC_BIR   = {{(IDX_W-1){1'b0}}, 1'b1};

    durum_e             durum_q, durum_d;
    logic [IDX_W-1:0]   sayac_q, sayac_d;
    logic [31:2]        adres_q, adres_d;
    logic               yanit_q, yanit_d;
    logic [31:0]        yanit_veri_q, yanit_veri_d;
    logic               bitti_q, bitti_d;
    // Low for the first cycle after reset so nothing is driven while rst_ni is low.
    logic               aktif_q;

    logic [IDX_W-1:0]   indeks_s;
    logic [TAG_W-1:0]   etiket_s;
    logic               isabet_s;
    logic               unused_s;

    assign indeks_s = adres_q[IDX_W+1:2];
    assign etiket_s = adres_q[IDX_W+TAG_W+1:IDX_W+2];
    assign isabet_s = girdi_isabet(ram_data_i, etiket_s);
    // The byte offset of a fetch address has no meaning for word fetches.
    assign unused_s = ^ist_adres_i[1:0];

    // State, counter and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            durum_q      <= TEMIZLE;
            sayac_q      <= SAYAC_SIFIR;
            adres_q      <= 30'd0;
            yanit_q      <= 1'b0;
            yanit_veri_q <= 32'd0;
            bitti_q      <= 1'b0;
            aktif_q      <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            sayac_q      <= sayac_d;
            adres_q      <= adres_d;
            yanit_q      <= yanit_d;
            yanit_veri_q <= yanit_veri_d;
            bitti_q      <= bitti_d;
            aktif_q      <= 1'b1;
        end
    end

    // Next-state logic: sweep, accept, lookup, refill request, refill wait, write.
    always_comb begin
        durum_d      = durum_q;
        sayac_d      = sayac_q;
        adres_d      = adres_q;
        yanit_d      = 1'b0;
        yanit_veri_d = yanit_veri_q;
        bitti_d      = 1'b0;
        if (aktif_q) begin
            case (durum_q)
                TEMIZLE: begin
                    if (sayac_q == SAYAC_SON) begin
                        sayac_d = SAYAC_SIFIR;
                        bitti_d = 1'b1;
                        durum_d = BOSTA;
                    end else begin
                        sayac_d = sayac_q + SAYAC_BIR;
                    end
                end
                BOSTA: begin
                    // A flush takes priority; the simultaneous fetch is not accepted.
                    if (temizle_i) begin
                        sayac_d = SAYAC_SIFIR;
                        durum_d = TEMIZLE;
                    end else if (ist_gecerli_i) begin
                        adres_d = ist_adres_i[31:2];
                        durum_d = ARA;
                    end else begin
                        durum_d = BOSTA;
                    end
                end
                ARA: begin
                    if (isabet_s) begin
                        yanit_d      = 1'b1;
                        yanit_veri_d = ram_data_i[DATA_MSB:0];
                        durum_d      = BOSTA;
                    end else begin
                        durum_d = ISTEK;
                    end
                end
                ISTEK: begin
                    if (bel_hazir_i) begin
                        durum_d = BEKLE;
                    end else begin
                        durum_d = ISTEK;
                    end
                end
                BEKLE: begin
                    // The refill word is answered in YAZ straight from this register.
                    if (bel_yanit_gecerli_i) begin
                        yanit_d      = 1'b1;
                        yanit_veri_d = bel_veri_i;
                        durum_d      = YAZ;
                    end else begin
                        durum_d = BEKLE;
                    end
                end
                YAZ: begin
                    durum_d = BOSTA;
                end
                default: begin
                    sayac_d = SAYAC_SIFIR;
                    durum_d = TEMIZLE;
                end
            endcase
        end else begin
            durum_d = durum_q;
        end
    end

    // Output decode from registered state; everything is quiet until aktif_q.
    always_comb begin
        ist_hazir_o         = 1'b0;
        bel_istek_gecerli_o = 1'b0;
        bel_adres_o         = 32'd0;
        ram_wen_o           = 5'b00000;
        ram_data_o          = 41'd0;
        ram_wadr_o          = SAYAC_SIFIR;
        if (aktif_q) begin
            case (durum_q)
                TEMIZLE: begin
                    ram_wen_o  = WEN_INV;
                    ram_wadr_o = sayac_q;
                end
                BOSTA: begin
                    ist_hazir_o = ~temizle_i;
                end
                ISTEK: begin
                    bel_istek_gecerli_o = 1'b1;
                    bel_adres_o         = {adres_q, 2'b00};
                end
                YAZ: begin
                    ram_wen_o  = WEN_ALL;
                    ram_data_o = girdi_olustur(etiket_s, yanit_veri_q);
                    ram_wadr_o = indeks_s;
                end
                default: begin
                    ram_wen_o = 5'b00000;
                end
            endcase
        end else begin
            ram_wen_o = 5'b00000;
        end
    end

    assign yanit_gecerli_o = yanit_q;
    assign yanit_buyruk_o  = yanit_veri_q;
    assign temizle_bitti_o = bitti_q;
    assign ram_radr_o      = indeks_s;

endmodule

// File: tb/tb_buyruk_onbellek_denetleyici.sv
// Self-checking bench: directed scenarios plus random fetches against a
// tag/valid reference model and a word-per-address memory model.
module tb_buyruk_onbellek_denetleyici;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ist_gecerli_i;
    logic [31:0] ist_adres_i;
    logic        ist_hazir_o;
    logic        yanit_gecerli_o;
    logic [31:0] yanit_buyruk_o;
    logic        temizle_i;
    logic        temizle_bitti_o;
    logic        bel_istek_gecerli_o;
    logic [31:0] bel_adres_o;
    logic        bel_hazir_i;
    logic        bel_yanit_gecerli_i;
    logic [31:0] bel_veri_i;
    logic [4:0]  ram_wen_o;
    logic [40:0] ram_data_o;
    logic [8:0]  ram_wadr_o;
    logic [8:0]  ram_radr_o;
    logic [40:0] ram_data_i;

    always #5 clk_i = ~clk_i;

    buyruk_onbellek_denetleyici dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ist_gecerli_i(ist_gecerli_i), .ist_adres_i(ist_adres_i), .ist_hazir_o(ist_hazir_o),
        .yanit_gecerli_o(yanit_gecerli_o), .yanit_buyruk_o(yanit_buyruk_o),
        .temizle_i(temizle_i), .temizle_bitti_o(temizle_bitti_o),
        .bel_istek_gecerli_o(bel_istek_gecerli_o), .bel_adres_o(bel_adres_o),
        .bel_hazir_i(bel_hazir_i), .bel_yanit_gecerli_i(bel_yanit_gecerli_i), .bel_veri_i(bel_veri_i),
        .ram_wen_o(ram_wen_o), .ram_data_o(ram_data_o), .ram_wadr_o(ram_wadr_o),
        .ram_radr_o(ram_radr_o), .ram_data_i(ram_data_i)
    );

    // buyruk_ffram stand-in: lane-enabled synchronous write, combinational read.
    logic [40:0] ram_m [0:511];
    logic        ram_yukle;
    always @(posedge clk_i) begin
        if (ram_yukle) begin
            for (int i = 0; i < 512; i++) ram_m[i] <= {1'b1, 8'($urandom), $urandom};
        end else begin
            if (ram_wen_o[4]) ram_m[ram_wadr_o][40]    <= ram_data_o[40];
            if (ram_wen_o[3]) ram_m[ram_wadr_o][39:32] <= ram_data_o[39:32];
            if (ram_wen_o[2]) ram_m[ram_wadr_o][31:24] <= ram_data_o[31:24];
            if (ram_wen_o[1]) ram_m[ram_wadr_o][23:16] <= ram_data_o[23:16];
            if (ram_wen_o[0]) ram_m[ram_wadr_o][15:0]  <= ram_data_o[15:0];
        end
    end
    assign ram_data_i = ram_m[ram_radr_o];

    // Reference model: which tag each index holds, and the program memory.
    bit          m_vld [0:511];
    logic [7:0]  m_tag [0:511];
    logic [31:0] mem [int];

    int n_cmp = 0;
    int n_err = 0;

    // Results of the last fetch.
    bit          f_acc;
    int          f_resp, f_lat, f_hs, f_dt;
    logic [31:0] f_data, f_adr;
    bit          f_stab;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) m_vld[i] = 1'b0;
    endtask

    // Program space is 512 KiB; words alias above address bit 18.
    task automatic get_word(input logic [31:0] a, output logic [31:0] w);
        int key;
        key = int'(a[18:2]);
        if (!mem.exists(key)) mem[key] = $urandom;
        w = mem[key];
    endtask

    // Watches a whole invalidation sweep starting in the current cycle.
    task automatic sweep_check(input string nm);
        int wen_n = 0, bad = 0, bitti_n = 0, bitti_c = -1, last_c = -1, hz_c = -1, resp = 0, req = 0;
        for (int c = 0; c < 560; c++) begin
            if (ram_wen_o == 5'b10000) begin
                if (ram_wadr_o !== wen_n[8:0]) bad++;
                if (ram_data_o !== 41'd0) bad++;
                wen_n++;
                last_c = c;
            end else if (ram_wen_o !== 5'b00000) begin
                bad++;
            end
            if (temizle_bitti_o) begin bitti_n++; bitti_c = c; end
            if (ist_hazir_o && hz_c < 0) hz_c = c;
            if (yanit_gecerli_o) resp++;
            if (bel_istek_gecerli_o) req++;
            @(posedge clk_i); #1;
        end
        chk({nm, "_wen_cycles"}, 64'(wen_n), 64'd512);
        chk({nm, "_wadr_order"}, 64'(bad), 64'd0);
        chk({nm, "_bitti_count"}, 64'(bitti_n), 64'd1);
        chk({nm, "_bitti_cycle"}, 64'(bitti_c), 64'(last_c + 1));
        chk({nm, "_hazir_cycle"}, 64'(hz_c), 64'(last_c + 1));
        chk({nm, "_no_resp"}, 64'(resp), 64'd0);
        chk({nm, "_no_memreq"}, 64'(req), 64'd0);
    endtask

    // Issues one fetch and plays the memory side with a given stall and data delay.
    task automatic fetch(input logic [31:0] a, input int stall, input int dly, input logic [31:0] w);
        int req_c = 0, wc = 0;
        bit pend = 1'b0, first = 1'b1;
        f_acc = 1'b0; f_resp = 0; f_lat = -1; f_hs = 0; f_dt = -1;
        f_data = 32'd0; f_adr = 32'd0; f_stab = 1'b1;
        ist_adres_i = a;
        ist_gecerli_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            f_acc = ist_hazir_o;
            @(posedge clk_i); #1;
            if (f_acc) break;
        end
        ist_gecerli_i = 1'b0;
        if (f_acc) begin
            for (int t = 1; t < 120; t++) begin
                if (yanit_gecerli_o) begin
                    if (f_resp == 0) begin f_lat = t; f_data = yanit_buyruk_o; end
                    f_resp++;
                end
                if (pend) begin
                    if (wc == dly) begin
                        bel_yanit_gecerli_i = 1'b1; bel_veri_i = w; f_dt = t; pend = 1'b0;
                    end else begin
                        bel_yanit_gecerli_i = 1'b0; wc++;
                    end
                end else begin
                    bel_yanit_gecerli_i = 1'b0;
                end
                if (bel_istek_gecerli_o) begin
                    req_c++;
                    if (first) begin f_adr = bel_adres_o; first = 1'b0; end
                    else if (bel_adres_o !== f_adr) f_stab = 1'b0;
                    if (req_c > stall) begin
                        bel_hazir_i = 1'b1; f_hs++; pend = 1'b1; wc = 0;
                    end else begin
                        bel_hazir_i = 1'b0;
                    end
                end else begin
                    bel_hazir_i = 1'b0;
                end
                if (f_resp > 0 && t >= f_lat + 2) break;
                @(posedge clk_i); #1;
            end
        end
        bel_hazir_i = 1'b0;
        bel_yanit_gecerli_i = 1'b0;
        bel_veri_i = 32'd0;
    endtask

    // Fetch plus every expectation the reference model can derive for it.
    task automatic check_fetch(input string nm, input logic [31:0] a, input int stall, input int dly);
        logic [8:0]  idx;
        logic [7:0]  tag;
        logic [31:0] w;
        bit          hit;
        idx = a[10:2];
        tag = a[18:11];
        hit = m_vld[idx] && (m_tag[idx] == tag);
        get_word(a, w);
        fetch(a, stall, dly, w);
        chk({nm, "_accept"}, 64'(f_acc), 64'd1);
        chk({nm, "_resp_count"}, 64'(f_resp), 64'd1);
        chk({nm, "_data"}, 64'(f_data), 64'(w));
        chk({nm, "_memreq"}, 64'(f_hs), hit ? 64'd0 : 64'd1);
        chk({nm, "_latency"}, 64'(f_lat), hit ? 64'd2 : 64'(f_dt + 1));
        if (!hit) begin
            chk({nm, "_bel_adres"}, 64'(f_adr), 64'({a[31:2], 2'b00}));
            chk({nm, "_bel_stable"}, 64'(f_stab), 64'd1);
        end
        chk({nm, "_ram_entry"}, 64'(ram_m[idx]), 64'({1'b1, tag, w}));
        m_vld[idx] = 1'b1;
        m_tag[idx] = tag;
    endtask

    initial begin
        int          nvld;
        int          resp;
        logic [31:0] a;

        rst_ni = 1'b0; ist_gecerli_i = 1'b0; ist_adres_i = 32'd0; temizle_i = 1'b0;
        bel_hazir_i = 1'b0; bel_yanit_gecerli_i = 1'b0; bel_veri_i = 32'd0; ram_yukle = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        ram_yukle = 1'b0;

        // Reset state: every output quiet.
        chk("reset_outputs",
            64'({ist_hazir_o, yanit_gecerli_o, |yanit_buyruk_o, temizle_bitti_o, bel_istek_gecerli_o,
                 |bel_adres_o, |ram_wen_o, |ram_data_o, |ram_wadr_o, |ram_radr_o}), 64'd0);

        // Sweep after reset release clears every valid bit.
        rst_ni = 1'b1;
        sweep_check("sweep_reset");
        nvld = 0;
        for (int i = 0; i < 512; i++) if (ram_m[i][40]) nvld++;
        chk("sweep_valid_left", 64'(nvld), 64'd0);
        model_clear();

        // Cold miss, repeat hit, conflict miss, and re-miss of the evicted line.
        mem[int'(32'h104 >> 2)] = 32'h0051_0113;
        check_fetch("cold_miss", 32'h0000_0104, 0, 2);
        chk("cold_ram65", 64'(ram_m[65]), 64'h1_00_0051_0113);
        check_fetch("repeat_hit", 32'h0000_0104, 0, 0);
        check_fetch("conflict", 32'h0000_0904, 1, 1);
        chk("conflict_tag", 64'(ram_m[65][39:32]), 64'd1);
        check_fetch("re_miss", 32'h0000_0104, 0, 0);

        // Memory stall: seven refused request cycles, then data three cycles later.
        check_fetch("stall", 32'h0000_1a3c, 7, 3);

        // Flush wins over a simultaneous fetch.
        ist_adres_i = 32'h0000_0104;
        temizle_i = 1'b1;
        ist_gecerli_i = 1'b1;
        #1;
        chk("flush_hazir_low", 64'(ist_hazir_o), 64'd0);
        @(posedge clk_i); #1;
        temizle_i = 1'b0;
        ist_gecerli_i = 1'b0;
        sweep_check("sweep_flush");
        model_clear();
        check_fetch("post_flush", 32'h0000_0104, 0, 1);

        // Reset while waiting for refill data: no response, sweep restarts at 0.
        ist_adres_i = 32'h0000_0208;
        ist_gecerli_i = 1'b1;
        #1;
        chk("b6_hazir", 64'(ist_hazir_o), 64'd1);
        @(posedge clk_i); #1;
        ist_gecerli_i = 1'b0;
        @(posedge clk_i); #1;
        chk("b6_memreq", 64'(bel_istek_gecerli_o), 64'd1);
        bel_hazir_i = 1'b1;
        @(posedge clk_i); #1;
        bel_hazir_i = 1'b0;
        chk("b6_waiting", 64'(bel_istek_gecerli_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        resp = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (yanit_gecerli_o) resp++;
        end
        chk("b6_no_resp", 64'(resp), 64'd0);
        rst_ni = 1'b1;
        sweep_check("sweep_rst");
        model_clear();

        // Random fetches over a few indices and tags, with aliasing high bits.
        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            a[18:11] = 8'($urandom_range(0, 2));
            a[10:2]  = 9'($urandom_range(0, 5));
            check_fetch("rand", a, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
